// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: data-memory req/gnt/rvalid handshake, load alignment/extension, registered MEM/WB bundle.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses skip memory and report o_misalign.
module mem_access_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_rd,
  input  logic              i_ex_mem_wr,
  input  logic [2:0]        i_ex_funct3,
  input  logic [XLEN-1:0]   i_ex_alu_result,
  input  logic [XLEN-1:0]   i_ex_store_data,
  input  logic [RD_W-1:0]   i_ex_rd,
  input  logic              i_ex_reg_write,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_dmem_req,
  input  logic              i_dmem_gnt,
  output logic              o_dmem_we,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN/8-1:0] o_dmem_be,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  output logic              o_wb_valid,
  output logic [RD_W-1:0]   o_wb_rd,
  output logic              o_wb_reg_write,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_misalign
);

  localparam int BW = XLEN / 8;
  localparam int LB = $clog2(BW);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nxt;

  // Incoming access decode
  logic [1:0]      in_size;
  logic [LB-1:0]   in_lane;
  logic [LB-1:0]   in_lane_al;
  logic [BW-1:0]   in_be;
  logic [XLEN-1:0] in_wdata;
  logic            mem_op;
  logic            accept;
  logic            trap;
  logic            mem_go;

  // Captured bundle for the in-flight access
  logic [1:0]      cap_size;
  logic            cap_uns;
  logic [LB-1:0]   cap_lane;
  logic            cap_we;
  logic [XLEN-1:0] cap_addr;
  logic [BW-1:0]   cap_be;
  logic [XLEN-1:0] cap_wdata;
  logic [XLEN-1:0] cap_alu;
  logic [RD_W-1:0] cap_rd;
  logic            cap_rw;
  logic            killed;

  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_top;
  logic [XLEN-1:0] ld_ext;
  int unsigned     sh;

  always_comb begin
    in_size = i_ex_funct3[1:0];
    if (XLEN == 32 && in_size == 2'd3) in_size = 2'd2;
    in_lane    = i_ex_alu_result[LB-1:0];
    in_lane_al = in_lane & ~(LB'((32'd1 << in_size) - 32'd1));
    in_be      = BW'(((32'd1 << (32'd1 << in_size)) - 32'd1) << in_lane_al);
    in_wdata   = i_ex_store_data << {in_lane_al, 3'b000};
  end

  assign mem_op = i_ex_mem_rd | i_ex_mem_wr;
  assign accept = (state == IDLE) & i_ex_valid & ~i_flush & ~i_rst;

`ifdef MISALIGN_TRAP_EN
  assign trap = accept & mem_op & ((in_lane & LB'((32'd1 << in_size) - 32'd1)) != '0);
`else
  assign trap = 1'b0;
`endif

  assign mem_go = accept & mem_op & ~trap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_dmem_req = 1'b0;
    o_stall    = 1'b0;
    case (state)
      IDLE: begin
        o_stall = mem_go;
        if (mem_go) state_nxt = REQ;
      end
      REQ: begin
        o_dmem_req = 1'b1;
        o_stall    = 1'b1;
        // A grant beats a flush: the access is already committed on the bus
        if (i_dmem_gnt)   state_nxt = cap_we ? IDLE : WAIT;
        else if (i_flush) state_nxt = IDLE;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_dmem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_shift = i_dmem_rdata >> {cap_lane, 3'b000};
    sh       = 32'(XLEN) - (32'd8 << cap_size);
    ld_top   = ld_shift << sh;
    ld_ext   = cap_uns ? (ld_top >> sh) : $unsigned($signed(ld_top) >>> sh);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_size       <= '0;
      cap_uns        <= 1'b0;
      cap_lane       <= '0;
      cap_we         <= 1'b0;
      cap_addr       <= '0;
      cap_be         <= '0;
      cap_wdata      <= '0;
      cap_alu        <= '0;
      cap_rd         <= '0;
      cap_rw         <= 1'b0;
      killed         <= 1'b0;
      o_wb_valid     <= 1'b0;
      o_wb_rd        <= '0;
      o_wb_reg_write <= 1'b0;
      o_wb_data      <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      if (mem_go) begin
        cap_size  <= in_size;
        cap_uns   <= i_ex_funct3[2];
        cap_lane  <= in_lane_al;
        cap_we    <= ~i_ex_mem_rd;
        cap_addr  <= {i_ex_alu_result[XLEN-1:LB], {LB{1'b0}}};
        cap_be    <= in_be;
        cap_wdata <= in_wdata;
        cap_alu   <= i_ex_alu_result;
        cap_rd    <= i_ex_rd;
        cap_rw    <= i_ex_reg_write;
        killed    <= 1'b0;
      end
      if (accept & (~mem_op | trap)) begin
        o_wb_valid     <= 1'b1;
        o_wb_rd        <= i_ex_rd;
        o_wb_reg_write <= i_ex_reg_write & ~trap;
        o_wb_data      <= i_ex_alu_result;
      end
      if (state == REQ && i_dmem_gnt) begin
        if (cap_we) begin
          if (!i_flush) begin
            o_wb_valid     <= 1'b1;
            o_wb_rd        <= cap_rd;
            o_wb_reg_write <= 1'b0;
            o_wb_data      <= cap_alu;
          end
        end else begin
          killed <= i_flush;
        end
      end
      if (state == WAIT) begin
        if (i_flush) killed <= 1'b1;
        if (i_dmem_rvalid && !killed && !i_flush) begin
          o_wb_valid     <= 1'b1;
          o_wb_rd        <= cap_rd;
          o_wb_reg_write <= cap_rw;
          o_wb_data      <= ld_ext;
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_misalign <= 1'b0;
    else       o_misalign <= trap;
  end
`else
  assign o_misalign = 1'b0;
`endif

  assign o_dmem_we    = cap_we;
  assign o_dmem_addr  = cap_addr;
  assign o_dmem_be    = cap_be;
  assign o_dmem_wdata = cap_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage with a byte-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_write, flush;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        wb_valid, wb_reg_write, misalign;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(64), .RD_W(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_valid(ex_valid), .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr),
    .i_ex_funct3(ex_funct3), .i_ex_alu_result(ex_alu_result), .i_ex_store_data(ex_store_data),
    .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_flush(flush),
    .o_stall(stall), .o_dmem_req(dmem_req), .i_dmem_gnt(dmem_gnt), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_reg_write(wb_reg_write),
    .o_wb_data(wb_data), .o_misalign(misalign)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdata);
    int n = 1 << f3[1:0];
    int lane = int'(addr[2:0]) / n * n;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(lane+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; flush = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  // Called at posedge+1 with the stage idle; returns at posedge+1 one cycle after the WB pulse.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [4:0] rd, input bit rw,
                        input int gd, input int rvd, input logic [63:0] rdata, input string tag);
    int stalls = 0;
    bit mem = ld | st;
    int n = 1 << f3[1:0];
    int lane = int'(addr[2:0]) / n * n;
    logic [7:0]  bexp = '0;
    logic [63:0] wmask = '0;
    logic [63:0] wexp = '0;
    for (int i = 0; i < n; i++) begin
      bexp[lane+i] = 1'b1;
      wmask[8*(lane+i) +: 8] = 8'hFF;
      wexp[8*(lane+i) +: 8]  = sdata[8*i +: 8];
    end
    ex_valid = 1; ex_mem_rd = ld; ex_mem_wr = st; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw;
    #1;
    check({tag, "_accept_stall"}, stall, mem);
    check({tag, "_accept_req"}, dmem_req, 0);
    stalls += int'(stall);
    tick();
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    if (!mem) begin
      check({tag, "_wb_valid"}, wb_valid, 1);
      check({tag, "_wb_rd"}, wb_rd, rd);
      check({tag, "_wb_data"}, wb_data, addr);
      check({tag, "_wb_rw"}, wb_reg_write, rw);
      check({tag, "_no_req"}, dmem_req, 0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        if (c == gd) dmem_gnt = 1;
        else if (ld) begin dmem_rvalid = 1; dmem_rdata = ~rdata; end
        #1;
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, st);
        check({tag, "_addr"}, dmem_addr, addr & ~64'h7);
        check({tag, "_be"}, dmem_be, bexp);
        if (st) check({tag, "_wdata"}, dmem_wdata & wmask, wexp);
        check({tag, "_wb_idle"}, wb_valid, 0);
        stalls += int'(stall);
        tick();
        dmem_gnt = 0; dmem_rvalid = 0;
      end
      if (st) begin
        check({tag, "_st_wb_valid"}, wb_valid, 1);
        check({tag, "_st_wb_rw"}, wb_reg_write, 0);
        check({tag, "_st_wb_rd"}, wb_rd, rd);
      end else begin
        for (int c = 1; c <= rvd; c++) begin
          if (c == rvd) begin dmem_rvalid = 1; dmem_rdata = rdata; end
          #1;
          check({tag, "_wait_req"}, dmem_req, 0);
          check({tag, "_wait_wb"}, wb_valid, 0);
          stalls += int'(stall);
          tick();
          dmem_rvalid = 0;
        end
        check({tag, "_ld_wb_valid"}, wb_valid, 1);
        check({tag, "_ld_wb_rd"}, wb_rd, rd);
        check({tag, "_ld_wb_rw"}, wb_reg_write, rw);
        check({tag, "_ld_wb_data"}, wb_data, load_model(f3, addr, rdata));
      end
      #1;
      check({tag, "_release"}, stall, 0);
      check({tag, "_stall_cycles"}, stalls, 2 + gd + (ld ? rvd : 0));
    end
    tick();
    check({tag, "_pulse"}, wb_valid, 0);
    check({tag, "_hold_rd"}, wb_rd, rd);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    ex_funct3 = '0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 0;
    dmem_rdata = '0;
    tick();
    tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_misalign", misalign, 0);
    rst = 0;
    tick();

    run_op(0, 0, 3'b000, 64'h1234, '0, 5'd5, 1, 0, 1, '0, "add");
    run_op(0, 1, 3'b010, 64'h104, 64'hDEADBEEF, 5'd0, 0, 1, 1, '0, "sw");
    run_op(1, 0, 3'b000, 64'h3, '0, 5'd7, 1, 0, 1, 64'h0000_0000_8000_0000, "lb");
    run_op(1, 0, 3'b100, 64'h3, '0, 5'd8, 1, 2, 2, 64'h0000_0000_8000_0000, "lbu");
    run_op(1, 0, 3'b011, 64'h40, '0, 5'd9, 1, 0, 1, 64'h8123_4567_89AB_CDEF, "ld");
    run_op(1, 0, 3'b110, 64'h44, '0, 5'd10, 1, 1, 3, 64'h8123_4567_89AB_CDEF, "lwu");
    run_op(1, 0, 3'b001, 64'h46, '0, 5'd11, 1, 0, 2, 64'h8123_4567_89AB_CDEF, "lh");

`ifdef MISALIGN_TRAP_EN
    ex_valid = 1; ex_mem_rd = 1; ex_funct3 = 3'b010; ex_alu_result = 64'h2; ex_rd = 5'd3; ex_reg_write = 1;
    #1;
    check("mis_stall", stall, 0);
    tick();
    idle_inputs();
    check("mis_req", dmem_req, 0);
    check("mis_wb_valid", wb_valid, 1);
    check("mis_wb_rw", wb_reg_write, 0);
    check("mis_flag", misalign, 1);
    tick();
    check("mis_flag_pulse", misalign, 0);
`else
    run_op(1, 0, 3'b010, 64'h2, '0, 5'd3, 1, 0, 1, 64'h1122_3344_5566_7788, "lw_unal");
    check("mis_tied", misalign, 0);
`endif

    // Flush together with a new op in IDLE: dropped
    ex_valid = 1; ex_mem_rd = 1; ex_funct3 = 3'b011; ex_alu_result = 64'h80; flush = 1;
    #1;
    check("fl_idle_stall", stall, 0);
    tick();
    idle_inputs();
    check("fl_idle_wb", wb_valid, 0);
    check("fl_idle_req", dmem_req, 0);

    // Flush in REQ without grant: request withdrawn, no WB
    ex_valid = 1; ex_mem_wr = 1; ex_funct3 = 3'b011; ex_alu_result = 64'h88;
    tick();
    idle_inputs();
    flush = 1;
    #1;
    check("fl_req_held", dmem_req, 1);
    tick();
    flush = 0;
    #1;
    check("fl_req_drop", dmem_req, 0);
    check("fl_req_stall", stall, 0);
    check("fl_req_wb", wb_valid, 0);
    tick();
    check("fl_req_wb2", wb_valid, 0);

    // Flush with grant on a store: write commits, no WB
    ex_valid = 1; ex_mem_wr = 1; ex_funct3 = 3'b000; ex_alu_result = 64'h91; ex_store_data = 64'hA5;
    tick();
    idle_inputs();
    flush = 1; dmem_gnt = 1;
    #1;
    check("fl_gnt_be", dmem_be, 8'h02);
    tick();
    idle_inputs();
    check("fl_gnt_wb", wb_valid, 0);
    #1;
    check("fl_gnt_idle", dmem_req | stall, 0);

    // Flush in WAIT: stall held until rvalid, data discarded
    ex_valid = 1; ex_mem_rd = 1; ex_funct3 = 3'b011; ex_alu_result = 64'hC0; ex_rd = 5'd12;
    tick();
    idle_inputs();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0; flush = 1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin dmem_rvalid = 1; dmem_rdata = 64'hFFFF; end
      #1;
      check("fl_wait_stall", stall, 1);
      tick();
      flush = 0; dmem_rvalid = 0;
      check("fl_wait_wb", wb_valid, 0);
    end
    #1;
    check("fl_wait_release", stall, 0);
    tick();
    check("fl_wait_wb2", wb_valid, 0);

    // Reset while waiting on load data
    ex_valid = 1; ex_mem_rd = 1; ex_funct3 = 3'b011; ex_alu_result = 64'hD0;
    tick();
    idle_inputs();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    rst = 1;
    #1;
    check("rst_wait_req", dmem_req, 0);
    check("rst_wait_stall", stall, 0);
    check("rst_wait_wb", wb_valid, 0);
    tick();
    rst = 0;
    tick();
    run_op(0, 0, 3'b000, 64'h55AA, '0, 5'd6, 1, 0, 1, '0, "post_rst");

    for (int k = 0; k < 40; k++) begin
      int kind = int'($urandom_range(0, 2));
      logic [2:0] f3 = (kind == 1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      logic [63:0] addr = {$urandom, $urandom};
      if (kind != 0) addr = addr & ~64'((1 << f3[1:0]) - 1);
      run_op(kind == 1, kind == 2, f3, addr, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), {$urandom, $urandom}, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
